// File: rtl/uart_tx_fifo.sv
// Byte FIFO between uart_rx and uart_tx in the UART echo path.
// Buffers received bytes and hands them to uart_tx one at a time over the
// start_send/done handshake, so a burst arriving while uart_tx is busy is kept.
// DEPTH must be a power of two and at least 2; AW is derived from it.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_byte,
    output logic          start_send,
    input  logic          tx_done
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic [7:0]     mem_q [DEPTH];

    logic           wr_accept;
    logic           pop;

    // Status flags come straight from the registered count, so a pop in the
    // same cycle never makes room for a write into a full FIFO.
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign tx_byte    = tx_byte_q;
    assign start_send = (state_q == SEND);

    // Write path, pop, occupancy and feeder next-state logic.
    always_comb begin
        wr_accept  = wr_en && !full;
        pop        = 1'b0;
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        tx_byte_d  = tx_byte_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_byte_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    state_d   = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        count_d = count_q + CW'(wr_accept) - CW'(pop);
    end

    // Control and status registers; reset abandons any queued bytes and any
    // outstanding wait for tx_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a byte scoreboard filled on each
// accepted write and drained on each start_send, plus a tx_done responder.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    tx_byte;
    logic          start_send;
    logic          tx_done;

    logic          man_done = 1'b0;
    logic          auto_pulse = 1'b0;
    bit            auto_done = 1'b0;
    bit            use_rand = 1'b0;
    int            delay = 4;
    int            done_cnt = 0;

    int            checks = 0;
    int            errors = 0;
    int            sends = 0;
    int            peak = 0;
    logic [7:0]    exp_q [$];

    assign tx_done = auto_pulse || man_done;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_byte    (tx_byte),
        .start_send (start_send),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every start_send must present the oldest accepted byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (32'(count) > peak) peak = 32'(count);
            if (start_send) begin
                sends++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_send", 32'(tx_byte), 32'hFFFF_FFFF);
                end else begin
                    check_eq("tx_byte_order", 32'(tx_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Model of uart_tx: answers each start_send with a one-cycle done pulse.
    always @(negedge clk) begin
        auto_pulse = 1'b0;
        if (rst) begin
            done_cnt = 0;
        end else if (start_send && auto_done) begin
            done_cnt = use_rand ? int'($urandom_range(50, 1)) : delay;
        end else if (done_cnt == 1) begin
            auto_pulse = 1'b1;
            done_cnt   = 0;
        end else if (done_cnt > 1) begin
            done_cnt--;
        end
    end

    // All tasks start and end 1 ns after a rising edge.
    task automatic wr(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && done_cnt == 0 && empty) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        cycles(3);
        check_eq(tag, 32'(n < 20000), 32'd1);
    endtask

    initial begin
        int base;
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset state
        cycles(2);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_tx_byte", 32'(tx_byte), 32'h00);
        check_eq("rst_start_send", 32'(start_send), 32'd0);
        rst = 1'b0;
        cycles(2);

        // Single byte: latency and a single start_send per tx_done
        base = sends;
        wr(8'hA5, 1'b1);
        check_eq("single_empty_k", 32'(empty), 32'd0);
        check_eq("single_count_k", 32'(count), 32'd1);
        check_eq("single_ss_k", 32'(start_send), 32'd0);
        cycles(1);
        check_eq("single_tx_byte", 32'(tx_byte), 32'hA5);
        check_eq("single_count_k1", 32'(count), 32'd0);
        check_eq("single_ss_k1", 32'(start_send), 32'd1);
        cycles(1);
        check_eq("single_ss_k2", 32'(start_send), 32'd0);
        cycles(20);
        check_eq("single_no_resend", 32'(sends - base), 32'd1);
        pulse_done();
        cycles(5);
        check_eq("single_after_done", 32'(sends - base), 32'd1);
        check_eq("single_tx_hold", 32'(tx_byte), 32'hA5);

        // Burst while busy, tx_done 100 cycles after each start_send
        base      = sends;
        peak      = 0;
        auto_done = 1'b1;
        delay     = 100;
        for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
        wait_drain("burst_drain");
        check_eq("burst_sends", 32'(sends - base), 32'd5);
        check_eq("burst_peak", 32'(peak), 32'd4);
        check_eq("burst_overflow", 32'(overflow), 32'd0);

        // Fill and overflow with tx_done held off
        base      = sends;
        auto_done = 1'b0;
        for (int i = 0; i < 18; i++) wr(8'(8'h10 + i), (i != 17));
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_count", 32'(count), 32'd16);
        check_eq("fill_overflow", 32'(overflow), 32'd1);
        check_eq("fill_first_popped", 32'(tx_byte), 32'h10);
        check_eq("fill_sends", 32'(sends - base), 32'd1);
        auto_done = 1'b1;
        delay     = 3;
        pulse_done();
        wait_drain("fill_drain");
        check_eq("fill_drain_sends", 32'(sends - base), 32'd17);
        check_eq("fill_drain_count", 32'(count), 32'd0);
        check_eq("fill_overflow_sticky", 32'(overflow), 32'd1);
        reset_dut();
        check_eq("overflow_cleared", 32'(overflow), 32'd0);

        // Wrap-around with random tx_done delays
        base     = sends;
        use_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (full && n < 2000) begin
                cycles(1);
                n++;
            end
            wr(8'(i * 7 + 3), 1'b1);
        end
        wait_drain("wrap_drain");
        use_rand = 1'b0;
        check_eq("wrap_sends", 32'(sends - base), 32'd40);
        check_eq("wrap_count", 32'(count), 32'd0);
        check_eq("wrap_empty", 32'(empty), 32'd1);
        check_eq("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("wrap_overflow", 32'(overflow), 32'd0);

        // Write and pop on the same edge
        auto_done = 1'b0;
        wr(8'hA0, 1'b1);
        cycles(3);
        wr(8'hA1, 1'b1);
        wr(8'hA2, 1'b1);
        wr(8'hA3, 1'b1);
        check_eq("same_count_pre", 32'(count), 32'd3);
        pulse_done();
        auto_done = 1'b1;
        delay     = 4;
        wr(8'hA4, 1'b1);
        check_eq("same_count_post", 32'(count), 32'd3);
        check_eq("same_tx_byte", 32'(tx_byte), 32'hA1);
        check_eq("same_start_send", 32'(start_send), 32'd1);
        wait_drain("same_drain");

        // Asynchronous reset while waiting for tx_done with 5 queued
        auto_done = 1'b0;
        wr(8'hB0, 1'b1);
        cycles(3);
        for (int i = 1; i <= 5; i++) wr(8'(8'hB0 + i), 1'b1);
        check_eq("mid_count_pre", 32'(count), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        check_eq("mid_count", 32'(count), 32'd0);
        check_eq("mid_empty", 32'(empty), 32'd1);
        check_eq("mid_full", 32'(full), 32'd0);
        check_eq("mid_tx_byte", 32'(tx_byte), 32'h00);
        check_eq("mid_start_send", 32'(start_send), 32'd0);
        check_eq("mid_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst  = 1'b0;
        base = sends;
        pulse_done();
        cycles(5);
        check_eq("mid_stale_done", 32'(sends - base), 32'd0);
        auto_done = 1'b1;
        wr(8'h3C, 1'b1);
        wait_drain("mid_new_drain");
        check_eq("mid_new_sends", 32'(sends - base), 32'd1);
        check_eq("mid_new_tx_byte", 32'(tx_byte), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
